// File: rtl/mem_stage.sv
// Memory-access stage: registers execute results, runs loads/stores over a req/ack port,
// and formats write-back data. Optional misaligned-access trap: MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_fp_dest,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        wb_fp_dest,
    output logic        wb_misalign
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q, state_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    logic        fp_dest_q, fp_dest_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic        wb_fp_dest_q, wb_fp_dest_d;

    logic        is_store, mem_op;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [1:0]  ld_lane;
    logic [31:0] ld_shifted;
    logic [31:0] ld_data;

    assign is_store = ex_mem_write;
    assign mem_op   = ex_mem_write | ex_mem_read;

    // x0 is hardwired zero; f0 is an ordinary register
    function automatic logic wr_en(input logic we, input logic [4:0] rd, input logic fp);
        return we & ~((rd == 5'd0) & ~fp);
    endfunction

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ex_rs2;
        case (ex_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << ex_result[1:0];
                st_wdata = {4{ex_rs2[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {ex_result[1], 1'b0};
                st_wdata = {2{ex_rs2[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = ex_rs2;
            end
        endcase
    end

    // halfword lane is forced to addr[1]; words are never shifted
    always_comb begin
        ld_lane = 2'b00;
        case (funct3_q[1:0])
            2'b00:   ld_lane = addr_q[1:0];
            2'b01:   ld_lane = {addr_q[1], 1'b0};
            default: ld_lane = 2'b00;
        endcase
        ld_shifted = dmem_rdata >> {ld_lane, 3'b000};
        ld_data    = ld_shifted;
        case (funct3_q[1:0])
            2'b00:   ld_data = {{24{ld_shifted[7] & ~funct3_q[2]}}, ld_shifted[7:0]};
            2'b01:   ld_data = {{16{ld_shifted[15] & ~funct3_q[2]}}, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic misalign;
    logic wb_misalign_q, wb_misalign_d;

    always_comb begin
        misalign = 1'b0;
        case (ex_funct3[1:0])
            2'b01:   misalign = ex_result[0];
            2'b10:   misalign = (ex_result[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
    end
`endif

    always_comb begin
        state_d        = state_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        addr_d         = addr_q;
        dmem_be_d      = dmem_be_q;
        dmem_wdata_d   = dmem_wdata_q;
        funct3_d       = funct3_q;
        rd_d           = rd_q;
        reg_write_d    = reg_write_q;
        fp_dest_d      = fp_dest_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_fp_dest_d   = wb_fp_dest_q;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        wb_misalign_d  = wb_misalign_q;
`endif
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (!mem_op) begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = ex_result;
                        wb_rd_d        = ex_rd;
                        wb_reg_write_d = wr_en(ex_reg_write, ex_rd, ex_fp_dest);
                        wb_fp_dest_d   = ex_fp_dest;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                        wb_misalign_d  = 1'b0;
                    end else if (misalign) begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = ex_result;
                        wb_rd_d        = ex_rd;
                        wb_reg_write_d = 1'b0;
                        wb_fp_dest_d   = ex_fp_dest;
                        wb_misalign_d  = 1'b1;
`endif
                    end else begin
                        state_d      = ACCESS;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = is_store;
                        addr_d       = ex_result;
                        dmem_be_d    = is_store ? st_be : 4'b1111;
                        dmem_wdata_d = is_store ? st_wdata : 32'd0;
                        funct3_d     = ex_funct3;
                        rd_d         = ex_rd;
                        reg_write_d  = ex_reg_write & ~is_store;
                        fp_dest_d    = ex_fp_dest;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_d        = IDLE;
                    dmem_req_d     = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_data_d      = dmem_we_q ? addr_q : ld_data;
                    wb_rd_d        = rd_q;
                    wb_reg_write_d = wr_en(reg_write_q, rd_q, fp_dest_q);
                    wb_fp_dest_d   = fp_dest_q;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                    wb_misalign_d  = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            addr_q         <= 32'd0;
            dmem_be_q      <= 4'd0;
            dmem_wdata_q   <= 32'd0;
            funct3_q       <= 3'd0;
            rd_q           <= 5'd0;
            reg_write_q    <= 1'b0;
            fp_dest_q      <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= 32'd0;
            wb_rd_q        <= 5'd0;
            wb_reg_write_q <= 1'b0;
            wb_fp_dest_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            addr_q         <= addr_d;
            dmem_be_q      <= dmem_be_d;
            dmem_wdata_q   <= dmem_wdata_d;
            funct3_q       <= funct3_d;
            rd_q           <= rd_d;
            reg_write_q    <= reg_write_d;
            fp_dest_q      <= fp_dest_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_fp_dest_q   <= wb_fp_dest_d;
        end
    end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) wb_misalign_q <= 1'b0;
        else     wb_misalign_q <= wb_misalign_d;
    end
    assign wb_misalign = wb_misalign_q;
`else
    assign wb_misalign = 1'b0;
`endif

    assign ex_ready     = (state_q == IDLE);
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = {addr_q[31:2], 2'b00};
    assign dmem_be      = dmem_be_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_fp_dest   = wb_fp_dest_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard of expected write-backs checked by a wb monitor.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_result, ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_fp_dest, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_reg_write, wb_fp_dest, wb_misalign;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic [4:0]  rd;
        logic        rw;
        logic        fp;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_fp_dest(ex_fp_dest),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_fp_dest(wb_fp_dest), .wb_misalign(wb_misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // write-back monitor: every pulse must match the oldest expectation
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_data) chk("wb_data", wb_data, e.data);
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                chk("wb_fp_dest", 32'(wb_fp_dest), 32'(e.fp));
                chk("wb_misalign", 32'(wb_misalign), 32'(e.mis));
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic cd, input logic [4:0] rd,
                        input logic rw, input logic fp, input logic mis);
        exp_t e;
        e.data = d; e.chk_data = cd; e.rd = rd; e.rw = rw; e.fp = fp; e.mis = mis;
        sb.push_back(e);
    endtask

    // called at posedge+1; presents one instruction for exactly one cycle
    task automatic send(input logic [31:0] res, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic fp, input logic mr, input logic mw,
                        input logic [2:0] f3);
        ex_valid = 1'b1; ex_result = res; ex_rs2 = rs2; ex_rd = rd; ex_reg_write = rw;
        ex_fp_dest = fp; ex_mem_read = mr; ex_mem_write = mw; ex_funct3 = f3;
        chk("ex_ready_accept", 32'(ex_ready), 32'd1);
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    endtask

    // checks the outstanding request, holds it for dly cycles, then acks with rdata
    task automatic serve(input int dly, input logic [31:0] rdata, input logic [31:0] addr,
                         input logic [3:0] be, input logic we, input logic [31:0] wdata,
                         input logic chk_wdata);
        chk("dmem_req", 32'(dmem_req), 32'd1);
        chk("dmem_addr", dmem_addr, addr);
        chk("dmem_be", 32'(dmem_be), 32'(be));
        chk("dmem_we", 32'(dmem_we), 32'(we));
        if (chk_wdata) chk("dmem_wdata", dmem_wdata, wdata);
        chk("ex_ready_busy", 32'(ex_ready), 32'd0);
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
            chk("dmem_req_held", 32'(dmem_req), 32'd1);
            chk("dmem_addr_held", dmem_addr, addr);
            chk("ex_ready_held", 32'(ex_ready), 32'd0);
        end
        dmem_ack = 1'b1; dmem_rdata = rdata;
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = 32'hDEAD_0000;
        chk("dmem_req_drop", 32'(dmem_req), 32'd0);
        chk("ex_ready_done", 32'(ex_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_result = 32'd0; ex_rs2 = 32'd0; ex_rd = 5'd0;
        ex_reg_write = 1'b0; ex_fp_dest = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_funct3 = 3'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_be", 32'(dmem_be), 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_rw", 32'(wb_reg_write), 32'd0);
        chk("rst_wb_fp", 32'(wb_fp_dest), 32'd0);
        chk("rst_wb_mis", 32'(wb_misalign), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ALU ops back to back, including an x0 write that must be suppressed
        push(32'h0000_1234, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        send(32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        push(32'hCAFE_0001, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        send(32'hCAFE_0001, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("ex_ready_alu", 32'(ex_ready), 32'd1);
        @(posedge clk); #1;
        chk("wb_hold_data", wb_data, 32'hCAFE_0001);
        chk("wb_hold_valid", 32'(wb_valid), 32'd0);

        // LB 0x103, three wait cycles
        push(32'hFFFF_FF80, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        send(32'h0000_0103, 32'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000);
        serve(3, 32'h80AA_BBCC, 32'h0000_0100, 4'b1111, 1'b0, 32'd0, 1'b0);

        // SH 0x202, immediate ack
        push(32'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0202, 32'h0000_BEEF, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001);
        serve(0, 32'd0, 32'h0000_0200, 4'b1100, 1'b1, 32'hBEEF_BEEF, 1'b1);

        // SB 0x101 with both read and write set: store wins
        push(32'd0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0101, 32'h1234_565A, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000);
        serve(1, 32'd0, 32'h0000_0100, 4'b0010, 1'b1, 32'h5A5A_5A5A, 1'b1);

        // FLW to f0 is a real write
        push(32'h3F80_0000, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
        send(32'h0000_0040, 32'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010);
        serve(0, 32'h3F80_0000, 32'h0000_0040, 4'b1111, 1'b0, 32'd0, 1'b0);

        // LHU / LH on upper halfword
        push(32'h0000_8001, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        send(32'h0000_0102, 32'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 3'b101);
        serve(2, 32'h8001_0000, 32'h0000_0100, 4'b1111, 1'b0, 32'd0, 1'b0);
        push(32'hFFFF_8001, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        send(32'h0000_0102, 32'd0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001);
        serve(0, 32'h8001_0000, 32'h0000_0100, 4'b1111, 1'b0, 32'd0, 1'b0);

        // LBU lane 2
        push(32'h0000_00AA, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        send(32'h0000_0106, 32'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 3'b100);
        serve(0, 32'h80AA_BBCC, 32'h0000_0104, 4'b1111, 1'b0, 32'd0, 1'b0);

        // misaligned LW 0x41
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        push(32'h0000_0041, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1);
        send(32'h0000_0041, 32'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010);
        chk("trap_no_req", 32'(dmem_req), 32'd0);
        chk("trap_ex_ready", 32'(ex_ready), 32'd1);
`else
        push(32'h1122_3344, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        send(32'h0000_0041, 32'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010);
        serve(0, 32'h1122_3344, 32'h0000_0040, 4'b1111, 1'b0, 32'd0, 1'b0);
`endif
        @(posedge clk); #1;

        // reset during ACCESS: request drops, nothing written back, late ack ignored
        send(32'h0000_0300, 32'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010);
        chk("pre_rst_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_req", 32'(dmem_req), 32'd0);
        chk("rst_mid_ready", 32'(ex_ready), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("late_ack_req", 32'(dmem_req), 32'd0);
        chk("late_ack_wbv", 32'(wb_valid), 32'd0);
        chk("late_ack_ready", 32'(ex_ready), 32'd1);
        repeat (2) @(posedge clk);

        // drain with a bound
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
